adder_seq_ctrl: RTL and testbench

- Multi-cycle sequencer that performs one WIDTH-bit addition (a + b + cin) by driving a single narrow CHUNK-bit adder slice over several cycles.
- Carry is propagated between chunks in a register.
- Sits between an operand source and a result sink, with valid/ready handshakes on both sides.
- Replaces a full-width combinational adder where timing or area requires it.

---
 rtl/adder_pkg.sv | 18 +
 rtl/adder_slice.sv | 20 ++
 rtl/adder_seq_ctrl.sv | 107 ++++++++++
 tb/tb_adder_seq_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and constants for the chunked sequential adder.
package adder_pkg;

  localparam int DEF_WIDTH = 65;
  localparam int DEF_CHUNK = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of slice passes needed to cover n bits with d-bit chunks.
  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit adder slice with carry in/out.
module adder_slice #(
  parameter int CHUNK = adder_pkg::DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] t;

  // CHUNK+1-bit sum so the carry falls out as the top bit.
  always_comb begin
    t         = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    {cout, s} = t;
  end

endmodule

// File: rtl/adder_seq_ctrl.sv
// Multi-cycle WIDTH-bit adder: walks one CHUNK-bit slice across the
// zero-padded operands, carrying between chunks in a register.
module adder_seq_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NUM_CHUNKS = ceil_div(WIDTH, CHUNK);
  localparam int PW         = NUM_CHUNKS * CHUNK;
  localparam int IW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  state_t                               state;
  logic [NUM_CHUNKS-1:0][CHUNK-1:0]     opa, opb, res, res_nxt;
  logic [IW-1:0]                        idx;
  logic                                 carry;
  logic [CHUNK-1:0]                     sl_s;
  logic                                 sl_c;
  logic [PW:0]                          ext;
  logic                                 last;

  adder_slice #(.CHUNK(CHUNK)) u_slice (
    .a    (opa[idx]),
    .b    (opb[idx]),
    .cin  (carry),
    .s    (sl_s),
    .cout (sl_c)
  );

  // Result with the current chunk merged in; bit WIDTH of the padded
  // result is the true carry out of bit WIDTH-1 (the slice carry when
  // the top chunk is full, a padding bit when it is partial).
  always_comb begin
    res_nxt      = res;
    res_nxt[idx] = sl_s;
    ext          = {sl_c, res_nxt};
    last         = (idx == IW'(NUM_CHUNKS - 1));
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      idx       <= '0;
      carry     <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      res       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa      <= PW'(a);
            opb      <= PW'(b);
            carry    <= cin;
            idx      <= '0;
            res      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          res   <= res_nxt;
          carry <= sl_c;
          if (last) begin
            sum       <= ext[WIDTH-1:0];
            cout      <= ext[WIDTH];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Scoreboard bench for adder_seq_ctrl: accepts push expected results,
// an independent monitor pops and compares on each output handshake.
module tb_adder_seq_ctrl;
  import adder_pkg::*;

  localparam int W  = DEF_WIDTH;
  localparam int C  = DEF_CHUNK;
  localparam int NC = (W + C - 1) / C;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ord_fix = 1'b1;
  logic         rnd_rdy = 1'b0;
  logic         rr = 1'b1;
  logic         out_ready;
  logic         in_ready, out_valid, cout, busy;
  logic [W-1:0] sum;

  assign out_ready = rnd_rdy ? rr : ord_fix;

  adder_seq_ctrl #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rr <= 1'($urandom_range(0, 1));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: record accepts, check outputs, latency, hold and handoff.
  logic         prev_ov = 1'b0;
  logic         prev_hs = 1'b0;
  logic [W-1:0] psum = '0;
  logic         pco = 1'b0;
  always @(negedge clk) begin
    logic [W:0] x;
    if (!rst_n) begin
      q.delete();
      prev_ov = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        x = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        q.push_back('{x[W-1:0], x[W], cyc + 1});
      end
      if (prev_hs) begin
        chk("handoff_out_valid", out_valid, 0);
        chk("handoff_in_ready", in_ready, 1);
      end
      if (out_valid) begin
        chk("busy_in_done", busy, 1);
        chk("in_ready_in_done", in_ready, 0);
        if (q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 0);
        end else begin
          if (!prev_ov) chk("latency", cyc - q[0].cyc, NC);
          else begin
            chk("hold_sum", sum, psum);
            chk("hold_cout", cout, pco);
          end
          if (out_ready) begin
            chk("sum", sum, q[0].s);
            chk("cout", cout, q[0].co);
            void'(q.pop_front());
          end
        end
      end
      prev_ov = out_valid;
      prev_hs = out_valid && out_ready;
      psum    = sum;
      pco     = cout;
    end
  end

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
    int   n;
    logic acc;
    n = 0;
    a = ia; b = ib; cin = ic; in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      n++;
    end while (!acc && n < 300);
    #1 in_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=no_accept expected=accept");
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || !in_ready) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL idle_timeout actual=busy expected=idle");
    end
  endtask

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] r;
    case ($urandom_range(0, 3))
      0: r = '1;
      1: r = '0;
      2: r = W'(1) << $urandom_range(0, W - 1);
      default: r = W'({$urandom(), $urandom(), $urandom()});
    endcase
    return r;
  endfunction

  logic [W-1:0] p64;

  initial begin
    p64 = W'(1) << 64;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed operations
    issue(W'(1), W'(1), 1'b1);
    wait_idle();
    issue('1, '0, 1'b1);
    wait_idle();
    issue(p64, p64, 1'b0);
    wait_idle();

    // Backpressure with new operands offered during the stall
    ord_fix = 1'b0;
    issue(p64, W'(5), 1'b0);
    begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!out_valid && n < 50);
      chk("bp_out_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    a = W'(3); b = W'(4); cin = 1'b1; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_stall_sum", sum, p64 + W'(5));
      chk("bp_stall_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    ord_fix = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_pending_accepted", busy, 1);
    wait_idle();

    // Reset in the middle of an operation
    issue(W'(7), W'(9), 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_sum", sum, 0);
    issue(W'(7), W'(9), 1'b0);
    wait_idle();

    // Randomized operands with random sink backpressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      issue(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
    end
    rnd_rdy = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
